// File: rtl/hazard_forward_unit_if.sv
// Bus between the pipeline datapath and the hazard/forwarding controller.
// master = pipeline side (drives stage fields), slave = hazard_forward_unit.
interface hazard_forward_unit_if #(
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 16
);
    logic [NUM_RD*AW-1:0] id_rs;
    logic [NUM_RD-1:0]    id_rs_used;
    logic [NUM_RD*AW-1:0] ex_rs;
    logic [AW-1:0]        ex_rd;
    logic                 ex_mem_read;
    logic [AW-1:0]        mem_rd;
    logic                 mem_reg_write;
    logic [AW-1:0]        wb_rd;
    logic                 wb_reg_write;
    logic                 mem_busy;
    logic [NUM_RD*2-1:0]  forward_sel;
    logic [NUM_RD-1:0]    id_wb_bypass;
    logic                 stall_if_id;
    logic                 flush_id_ex;
    logic                 freeze_all;
    logic [CNT_W-1:0]     load_use_cnt;
    logic [CNT_W-1:0]     mem_wait_cnt;

    modport master (
        output id_rs, id_rs_used, ex_rs, ex_rd, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
        input  forward_sel, id_wb_bypass, stall_if_id, flush_id_ex,
               freeze_all, load_use_cnt, mem_wait_cnt
    );

    modport slave (
        input  id_rs, id_rs_used, ex_rs, ex_rd, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
        output forward_sel, id_wb_bypass, stall_if_id, flush_id_ex,
               freeze_all, load_use_cnt, mem_wait_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX-stage forwarding selects, ID-stage WB bypass flags,
// load-use stall sequencer (LOAD_LAT bubbles) and whole-pipeline freeze on
// data-memory wait. Optional macro HAZ_STATS_EN builds the saturating
// load-use / memory-wait statistics counters; otherwise both read as 0.
module hazard_forward_unit #(
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_forward_unit_if.slave bus
);

    localparam int BW = $clog2(LOAD_LAT + 1);
    localparam logic [BW-1:0] BUB_INIT = BW'(LOAD_LAT - 1);
    localparam logic [BW-1:0] BUB_ONE  = BW'(1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    state_t        w_eff_state;
    logic [BW-1:0] r_bub;
    logic [BW-1:0] w_bub_next;
    logic          r_ret_ls;
    logic          w_ret_ls_next;
    logic          w_stall;
    logic          w_flush;
    logic          w_freeze;

    logic [NUM_RD*2-1:0] w_fwd;
    logic [NUM_RD-1:0]   w_byp;
    logic [NUM_RD-1:0]   w_id_match;
    logic                w_hazard;

    // Per-port forwarding, bypass and load-use match; register 0 never matches.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [AW-1:0] w_ex_rs_k;
            logic [AW-1:0] w_id_rs_k;
            logic          w_mem_hit;
            logic          w_wb_hit;
            assign w_ex_rs_k = bus.ex_rs[gi*AW +: AW];
            assign w_id_rs_k = bus.id_rs[gi*AW +: AW];
            assign w_mem_hit = bus.mem_reg_write && (bus.mem_rd != '0) &&
                               (bus.mem_rd == w_ex_rs_k);
            assign w_wb_hit  = bus.wb_reg_write && (bus.wb_rd != '0) &&
                               (bus.wb_rd == w_ex_rs_k);
            assign w_fwd[gi*2 +: 2] = w_mem_hit ? 2'b10 :
                                      w_wb_hit  ? 2'b01 : 2'b00;
            assign w_byp[gi] = bus.wb_reg_write && (bus.wb_rd != '0) &&
                               (bus.wb_rd == w_id_rs_k) && bus.id_rs_used[gi];
            assign w_id_match[gi] = bus.id_rs_used[gi] && (w_id_rs_k == bus.ex_rd);
        end
    endgenerate

    assign bus.forward_sel  = w_fwd;
    assign bus.id_wb_bypass = w_byp;
    assign w_hazard = bus.ex_mem_read && (bus.ex_rd != '0) && (|w_id_match);

    // While frozen the sequencer is parked in MEM_WAIT; the saved state is
    // what it behaves as once mem_busy drops, so that cycle is not lost.
    always_comb begin
        w_eff_state = r_state;
        if (r_state == ST_MEM_WAIT) begin
            w_eff_state = r_ret_ls ? ST_LOAD_STALL : ST_RUN;
        end
    end

    // Next-state and Mealy control outputs; mem_busy overrides everything.
    always_comb begin
        w_state_next  = r_state;
        w_bub_next    = r_bub;
        w_ret_ls_next = r_ret_ls;
        w_stall       = 1'b0;
        w_flush       = 1'b0;
        w_freeze      = 1'b0;
        if (bus.mem_busy) begin
            w_freeze      = 1'b1;
            w_state_next  = ST_MEM_WAIT;
            w_ret_ls_next = (w_eff_state == ST_LOAD_STALL);
        end else begin
            case (w_eff_state)
                ST_LOAD_STALL: begin
                    w_stall = 1'b1;
                    w_flush = 1'b1;
                    if (r_bub <= BUB_ONE) begin
                        w_bub_next   = '0;
                        w_state_next = ST_RUN;
                    end else begin
                        w_bub_next   = r_bub - BUB_ONE;
                        w_state_next = ST_LOAD_STALL;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    if (w_hazard) begin
                        w_stall = 1'b1;
                        w_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_bub_next   = BUB_INIT;
                            w_state_next = ST_LOAD_STALL;
                        end
                    end
                end
            endcase
        end
    end

    // Sequencer state register; reset aborts any stall or wait in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_bub    <= '0;
            r_ret_ls <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bub    <= w_bub_next;
            r_ret_ls <= w_ret_ls_next;
        end
    end

    assign bus.stall_if_id = w_stall  & rst_n;
    assign bus.flush_id_ex = w_flush  & rst_n;
    assign bus.freeze_all  = w_freeze & rst_n;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] r_load_use_cnt;
    logic [CNT_W-1:0] r_mem_wait_cnt;
    logic             w_lu_event;

    // A new hazard is only ever accepted from (effective) RUN.
    assign w_lu_event = w_stall && (w_eff_state == ST_RUN);

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_use_cnt <= '0;
            r_mem_wait_cnt <= '0;
        end else begin
            if (w_lu_event && !(&r_load_use_cnt)) begin
                r_load_use_cnt <= r_load_use_cnt + 1'b1;
            end
            if (w_freeze && !(&r_mem_wait_cnt)) begin
                r_mem_wait_cnt <= r_mem_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.load_use_cnt = r_load_use_cnt;
    assign bus.mem_wait_cnt = r_mem_wait_cnt;
`else
    assign bus.load_use_cnt = {CNT_W{1'b0}};
    assign bus.mem_wait_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: two instances (LOAD_LAT=1 and 3)
// share the same stimulus. Forwarding/bypass rows come from a vector table;
// the stall/freeze/reset corner cases are hand-written sequences.
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rst_n;
    logic [9:0] t_id_rs;
    logic [1:0] t_used;
    logic [9:0] t_ex_rs;
    logic [4:0] t_ex_rd;
    logic       t_exmr;
    logic [4:0] t_mem_rd;
    logic       t_mem_rw;
    logic [4:0] t_wb_rd;
    logic       t_wb_rw;
    logic       t_busy;

    hazard_forward_unit_if #(.AW(5), .NUM_RD(2), .CNT_W(16)) if_l1 ();
    hazard_forward_unit_if #(.AW(5), .NUM_RD(2), .CNT_W(16)) if_l3 ();

    assign if_l1.id_rs = t_id_rs;      assign if_l3.id_rs = t_id_rs;
    assign if_l1.id_rs_used = t_used;  assign if_l3.id_rs_used = t_used;
    assign if_l1.ex_rs = t_ex_rs;      assign if_l3.ex_rs = t_ex_rs;
    assign if_l1.ex_rd = t_ex_rd;      assign if_l3.ex_rd = t_ex_rd;
    assign if_l1.ex_mem_read = t_exmr; assign if_l3.ex_mem_read = t_exmr;
    assign if_l1.mem_rd = t_mem_rd;    assign if_l3.mem_rd = t_mem_rd;
    assign if_l1.mem_reg_write = t_mem_rw; assign if_l3.mem_reg_write = t_mem_rw;
    assign if_l1.wb_rd = t_wb_rd;      assign if_l3.wb_rd = t_wb_rd;
    assign if_l1.wb_reg_write = t_wb_rw; assign if_l3.wb_reg_write = t_wb_rw;
    assign if_l1.mem_busy = t_busy;    assign if_l3.mem_busy = t_busy;

    hazard_forward_unit #(.AW(5), .NUM_RD(2), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(t_rst_n), .bus(if_l1));
    hazard_forward_unit #(.AW(5), .NUM_RD(2), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(t_rst_n), .bus(if_l3));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0] id_rs;
        logic [1:0] used;
        logic [9:0] ex_rs;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [3:0] fwd;
        logic [1:0] byp;
    } vec_t;

    vec_t vt[11];

    function automatic int ec(input int n);
`ifdef HAZ_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        t_id_rs = '0; t_used = '0; t_ex_rs = '0; t_ex_rd = '0; t_exmr = 1'b0;
        t_mem_rd = '0; t_mem_rw = 1'b0; t_wb_rd = '0; t_wb_rw = 1'b0; t_busy = 1'b0;
    endtask

    task automatic load_hazard();
        t_exmr = 1'b1; t_ex_rd = 5'd7; t_id_rs = {5'd7, 5'd0}; t_used = 2'b10;
    endtask

    task automatic ctl(input string tag, input int stall_e, input int flush_e,
                       input int frz_e, input logic l3);
        if (l3) begin
            chk({tag, "_l3_stall"}, int'(if_l3.stall_if_id), stall_e);
            chk({tag, "_l3_flush"}, int'(if_l3.flush_id_ex), flush_e);
            chk({tag, "_l3_freeze"}, int'(if_l3.freeze_all), frz_e);
        end else begin
            chk({tag, "_l1_stall"}, int'(if_l1.stall_if_id), stall_e);
            chk({tag, "_l1_flush"}, int'(if_l1.flush_id_ex), flush_e);
            chk({tag, "_l1_freeze"}, int'(if_l1.freeze_all), frz_e);
        end
        $display("%s t=%0t l1 s/f/z=%b%b%b l3 s/f/z=%b%b%b", tag, $time,
                 if_l1.stall_if_id, if_l1.flush_id_ex, if_l1.freeze_all,
                 if_l3.stall_if_id, if_l3.flush_id_ex, if_l3.freeze_all);
    endtask

    initial begin
        //        id_rs           used   ex_rs           mem_rd mrw wb_rd wrw fwd      byp
        vt[0]  = '{{5'd0, 5'd0},  2'b00, {5'd5, 5'd5},  5'd5, 1'b1, 5'd5, 1'b1, 4'b1010, 2'b00};
        vt[1]  = '{{5'd0, 5'd0},  2'b00, {5'd5, 5'd5},  5'd5, 1'b0, 5'd5, 1'b1, 4'b0101, 2'b00};
        vt[2]  = '{{5'd0, 5'd0},  2'b00, {5'd5, 5'd5},  5'd0, 1'b1, 5'd0, 1'b1, 4'b0000, 2'b00};
        vt[3]  = '{{5'd0, 5'd0},  2'b00, {5'd3, 5'd5},  5'd5, 1'b1, 5'd3, 1'b1, 4'b0110, 2'b00};
        vt[4]  = '{{5'd0, 5'd0},  2'b00, {5'd0, 5'd0},  5'd0, 1'b1, 5'd0, 1'b1, 4'b0000, 2'b00};
        vt[5]  = '{{5'd4, 5'd9},  2'b01, {5'd1, 5'd2},  5'd0, 1'b0, 5'd9, 1'b1, 4'b0000, 2'b01};
        vt[6]  = '{{5'd4, 5'd9},  2'b00, {5'd1, 5'd2},  5'd0, 1'b0, 5'd9, 1'b1, 4'b0000, 2'b00};
        vt[7]  = '{{5'd9, 5'd9},  2'b11, {5'd9, 5'd7},  5'd7, 1'b1, 5'd9, 1'b0, 4'b0010, 2'b00};
        vt[8]  = '{{5'd9, 5'd9},  2'b11, {5'd9, 5'd7},  5'd7, 1'b1, 5'd9, 1'b1, 4'b0110, 2'b11};
        vt[9]  = '{{5'd0, 5'd0},  2'b11, {5'd6, 5'd6},  5'd6, 1'b1, 5'd6, 1'b1, 4'b1010, 2'b00};
        vt[10] = '{{5'd2, 5'd2},  2'b11, {5'd2, 5'd2},  5'd2, 1'b0, 5'd2, 1'b0, 4'b0000, 2'b00};

        // Reset: controls held at 0 even with mem_busy asserted.
        idle();
        t_rst_n = 1'b0;
        t_busy  = 1'b1;
        @(negedge clk);
        ctl("reset", 0, 0, 0, 1'b1);
        ctl("reset", 0, 0, 0, 1'b0);
        chk("reset_lu_cnt", int'(if_l3.load_use_cnt), 0);
        chk("reset_mw_cnt", int'(if_l3.mem_wait_cnt), 0);
        next_cyc();
        t_busy  = 1'b0;
        t_rst_n = 1'b1;

        // Forwarding / bypass table.
        for (int i = 0; i < 11; i++) begin
            t_id_rs = vt[i].id_rs; t_used = vt[i].used; t_ex_rs = vt[i].ex_rs;
            t_mem_rd = vt[i].mem_rd; t_mem_rw = vt[i].mem_rw;
            t_wb_rd = vt[i].wb_rd; t_wb_rw = vt[i].wb_rw;
            @(negedge clk);
            chk($sformatf("vec%0d_fwd", i), int'(if_l3.forward_sel), int'(vt[i].fwd));
            chk($sformatf("vec%0d_byp", i), int'(if_l3.id_wb_bypass), int'(vt[i].byp));
            chk($sformatf("vec%0d_fwd_l1", i), int'(if_l1.forward_sel), int'(vt[i].fwd));
            chk($sformatf("vec%0d_stall", i), int'(if_l1.stall_if_id), 0);
            $display("vec %0d fwd=%b byp=%b", i, if_l3.forward_sel, if_l3.id_wb_bypass);
            next_cyc();
        end
        idle();

        // Load-use: one bubble for LOAD_LAT=1, three for LOAD_LAT=3.
        load_hazard();
        @(negedge clk);
        ctl("lu_c1", 1, 1, 0, 1'b0);
        ctl("lu_c1", 1, 1, 0, 1'b1);
        next_cyc();
        idle();
        @(negedge clk);
        ctl("lu_c2", 0, 0, 0, 1'b0);
        ctl("lu_c2", 1, 1, 0, 1'b1);
        chk("lu_l1_cnt", int'(if_l1.load_use_cnt), ec(1));
        chk("lu_l3_cnt", int'(if_l3.load_use_cnt), ec(1));
        next_cyc();
        @(negedge clk);
        ctl("lu_c3", 1, 1, 0, 1'b1);
        next_cyc();
        @(negedge clk);
        ctl("lu_c4", 0, 0, 0, 1'b1);
        next_cyc();

        // Port 1 not actually read: no hazard.
        load_hazard();
        t_used = 2'b01;
        @(negedge clk);
        ctl("lu_unused", 0, 0, 0, 1'b0);
        ctl("lu_unused", 0, 0, 0, 1'b1);
        next_cyc();
        idle();

        // Clear counters, then freeze for 4 cycles starting at the 2nd bubble.
        t_rst_n = 1'b0;
        next_cyc();
        t_rst_n = 1'b1;
        load_hazard();
        @(negedge clk);
        ctl("mw_c1", 1, 1, 0, 1'b1);
        next_cyc();
        idle();
        t_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ctl($sformatf("mw_frz%0d", c), 0, 0, 1, 1'b1);
            chk($sformatf("mw_frz%0d_l1", c), int'(if_l1.freeze_all), 1);
            next_cyc();
        end
        t_busy = 1'b0;
        @(negedge clk);
        ctl("mw_b2", 1, 1, 0, 1'b1);
        next_cyc();
        @(negedge clk);
        ctl("mw_b3", 1, 1, 0, 1'b1);
        next_cyc();
        @(negedge clk);
        ctl("mw_run", 0, 0, 0, 1'b1);
        chk("mw_l3_wait_cnt", int'(if_l3.mem_wait_cnt), ec(4));
        chk("mw_l1_wait_cnt", int'(if_l1.mem_wait_cnt), ec(4));
        chk("mw_l3_lu_cnt", int'(if_l3.load_use_cnt), ec(1));
        next_cyc();

        // Reset in the middle of LOAD_STALL.
        load_hazard();
        @(negedge clk);
        ctl("rs_c1", 1, 1, 0, 1'b1);
        next_cyc();
        idle();
        t_busy  = 1'b1;
        t_rst_n = 1'b0;
        @(negedge clk);
        ctl("rs_hold", 0, 0, 0, 1'b1);
        next_cyc();
        t_busy  = 1'b0;
        t_rst_n = 1'b1;
        @(negedge clk);
        ctl("rs_after", 0, 0, 0, 1'b1);
        chk("rs_lu_cnt", int'(if_l3.load_use_cnt), 0);
        chk("rs_mw_cnt", int'(if_l3.mem_wait_cnt), 0);
        next_cyc();

        // Hazard coincident with mem_busy: freeze first, hazard counted after.
        load_hazard();
        t_busy = 1'b1;
        @(negedge clk);
        ctl("hb_frz", 0, 0, 1, 1'b0);
        next_cyc();
        t_busy = 1'b0;
        @(negedge clk);
        ctl("hb_stall", 1, 1, 0, 1'b0);
        chk("hb_lu_before", int'(if_l1.load_use_cnt), 0);
        next_cyc();
        idle();
        @(negedge clk);
        ctl("hb_done", 0, 0, 0, 1'b0);
        chk("hb_lu_after", int'(if_l1.load_use_cnt), ec(1));
        chk("hb_mw_after", int'(if_l1.mem_wait_cnt), ec(1));
        for (int c = 0; c < 4; c++) next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
